vdcorput_decode_32bit: RTL

VDCORPUT_DECODE_32BIT -- requirements
Module: vdcorput_decode_32bit

---
 rtl/lds_pkg.sv | 25 ++
 rtl/vdc_digit_step.sv | 23 ++
 rtl/vdcorput_decode_32bit.sv | 99 +++++++++
 3 files changed

// File: rtl/lds_pkg.sv
// Shared definitions for the low-discrepancy sequence blocks: legal radices,
// per-radix digit limits and the decoder FSM state type.
package lds_pkg;

    localparam int BASE_2 = 2;
    localparam int BASE_3 = 3;
    localparam int BASE_7 = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } vdc_state_e;

    // Largest digit count with BASE^DIGITS <= 2^32; zero marks an illegal base.
    function automatic int max_digits(input int base);
        case (base)
            BASE_2:  return 32;
            BASE_3:  return 20;
            BASE_7:  return 11;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/vdc_digit_step.sv
// One radix-BASE digit of Van der Corput inversion: peel the leading fraction
// digit off the residue and fold it into the index at the current weight.
module vdc_digit_step #(
    parameter int BASE = 2
) (
    input  logic [32:0] x,
    input  logic [31:0] acc,
    input  logic [31:0] weight,
    output logic [32:0] x_next,
    output logic [31:0] acc_next,
    output logic [31:0] weight_next
);

    logic [35:0] p;
    logic [2:0]  d;

    assign p           = {3'b000, x} * 36'(BASE);
    assign d           = p[35:33];
    assign x_next      = p[32:0];
    assign acc_next    = acc + ({29'd0, d} * weight);
    assign weight_next = weight * 32'(BASE);

endmodule

// File: rtl/vdcorput_decode_32bit.sv
// Recovers the sequence index k from a Q0.32 Van der Corput value by iterating
// a single digit-step datapath DIGITS times per input.
module vdcorput_decode_32bit
    import lds_pkg::*;
#(
    parameter int BASE   = 2,
    parameter int DIGITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_index,
    input  logic        out_ready
);

    localparam logic [5:0] CNT_LAST = 6'(DIGITS - 1);

    if (max_digits(BASE) == 0 || DIGITS < 1 || DIGITS > max_digits(BASE)) begin : g_bad_param
        $fatal(1, "vdcorput_decode_32bit: unsupported BASE/DIGITS combination");
    end

    vdc_state_e  state;
    logic [32:0] x;
    logic [31:0] acc;
    logic [31:0] weight;
    logic [5:0]  cnt;
    logic [32:0] x_next;
    logic [31:0] acc_next;
    logic [31:0] weight_next;

    vdc_digit_step #(.BASE(BASE)) u_step (
        .x           (x),
        .acc         (acc),
        .weight      (weight),
        .x_next      (x_next),
        .acc_next    (acc_next),
        .weight_next (weight_next)
    );

    // The trailing 1 places the residue at the midpoint of the truncation
    // interval, so each extracted digit is immune to the input's floor rounding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_index <= 32'd0;
            x         <= 33'd0;
            acc       <= 32'd0;
            weight    <= 32'd1;
            cnt       <= 6'd0;
        end else if (clear) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        x        <= {in_data, 1'b1};
                        acc      <= 32'd0;
                        weight   <= 32'd1;
                        cnt      <= 6'd0;
                        state    <= ST_RUN;
                        in_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    x      <= x_next;
                    acc    <= acc_next;
                    weight <= weight_next;
                    cnt    <= cnt + 6'd1;
                    if (cnt == CNT_LAST) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        out_index <= acc_next;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
